// File: rtl/ofdm_symbol_scheduler.sv
// OFDM symbol scheduler: splits the synchronised sample stream into 64-sample
// LTS / SIGNAL / DATA symbols, drives FFT and channel-estimator strobes, and ends or aborts frames.
module ofdm_symbol_scheduler #(
    parameter int SYM_LEN        = 64,
    parameter int LEN_WIDTH      = 12,
    parameter int SIG_WAIT_SYMS  = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       CLK,
    input  logic                       s_RST,
    input  logic                       in_strobe,
    input  logic                       in_providing_long,
    input  logic                       in_providing_stream,
    input  logic                       signal_valid,
    input  logic                       signal_ok,
    input  logic [LEN_WIDTH-1:0]       n_data_sym,
    input  logic                       fft_ready,
    output logic                       fft_start,
    output logic                       fft_in_valid,
    output logic                       chest_wr_en,
    output logic [1:0]                 sym_type,
    output logic [LEN_WIDTH-1:0]       sym_index,
    output logic [$clog2(SYM_LEN)-1:0] sample_index,
    output logic                       sym_last,
    output logic                       frame_done,
    output logic                       frame_error,
    output logic                       sync_reset_req,
    output logic                       busy
);

    localparam int SW = $clog2(SYM_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0]        LAST_SAMPLE = SW'(SYM_LEN - 1);
    localparam logic [TW-1:0]        IDLE_LIMIT  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_WIDTH-1:0] WAIT_SYMS   = LEN_WIDTH'(SIG_WAIT_SYMS);
    localparam logic [1:0]           TYPE_LTS    = 2'd0;
    localparam logic [1:0]           TYPE_SIG    = 2'd1;
    localparam logic [1:0]           TYPE_DATA   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LTS  = 2'd1,
        ST_SIG  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SW-1:0]          r_cnt;
    logic [LEN_WIDTH-1:0]   r_sym;
    logic [LEN_WIDTH-1:0]   r_limit;
    logic                   r_lim_vld;
    logic [TW-1:0]          r_idle;
    logic                   r_fft_start, r_fft_in_valid, r_chest_wr_en, r_sym_last;
    logic [1:0]             r_sym_type;
    logic [LEN_WIDTH-1:0]   r_sym_index;
    logic [SW-1:0]          r_sample_index;
    logic                   r_frame_done, r_frame_error, r_sync_reset_req, r_busy;

    logic                   w_acc_long, w_acc_strm, w_both, w_acc, w_in_frame;
    logic                   w_cnt_first, w_cnt_last;
    logic                   w_load, w_load_ok, w_lim_vld;
    logic [LEN_WIDTH-1:0]   w_lim, w_sym_inc;
    state_t                 w_nxt_state;
    logic [SW-1:0]          w_nxt_cnt;
    logic [LEN_WIDTH-1:0]   w_nxt_sym;
    logic [TW-1:0]          w_nxt_idle;
    logic                   w_fft_start, w_fft_valid, w_chest, w_last, w_done, w_err;
    logic [1:0]             w_type;
    logic [LEN_WIDTH-1:0]   w_index;
    logic [SW-1:0]          w_sidx;

    assign w_acc_long  = in_strobe & in_providing_long & ~in_providing_stream;
    assign w_acc_strm  = in_strobe & in_providing_stream & ~in_providing_long;
    assign w_both      = in_strobe & in_providing_long & in_providing_stream;
    assign w_acc       = w_acc_long | w_acc_strm;
    assign w_in_frame  = (r_state != ST_IDLE);
    assign w_cnt_first = (r_cnt == '0);
    assign w_cnt_last  = (r_cnt == LAST_SAMPLE);
    // Completed DATA symbol count saturates rather than wrapping.
    assign w_sym_inc   = (&r_sym) ? r_sym : r_sym + LEN_WIDTH'(1);
    // Only the first SIGNAL decode of a frame counts; a same-cycle load is visible to the end check.
    assign w_load      = signal_valid & ~r_lim_vld & ((r_state == ST_SIG) | (r_state == ST_DATA));
    assign w_load_ok   = w_load & signal_ok;
    assign w_lim       = w_load_ok ? n_data_sym : r_limit;
    assign w_lim_vld   = r_lim_vld | w_load_ok;

    // Next-state, sample tagging and end/abort decisions for the current cycle.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_sym   = r_sym;
        w_nxt_idle  = (w_in_frame && !w_acc) ? r_idle + TW'(1) : '0;
        w_fft_start = 1'b0;
        w_fft_valid = 1'b0;
        w_chest     = 1'b0;
        w_type      = TYPE_LTS;
        w_index     = '0;
        w_sidx      = '0;
        w_last      = 1'b0;
        w_done      = 1'b0;
        w_err       = (w_in_frame & w_both) | (w_load & ~signal_ok) |
                      (w_in_frame & ~w_acc & (r_idle == IDLE_LIMIT));
        case (r_state)
            ST_IDLE: begin
                if (w_acc_long) begin
                    w_nxt_state = ST_LTS;
                    w_chest     = 1'b1;
                    w_nxt_cnt   = SW'(1);
                end else begin
                    w_nxt_cnt   = '0;
                end
            end
            ST_LTS: begin
                if (w_acc_strm) begin
                    w_err = 1'b1;
                end else if (w_acc_long) begin
                    w_chest   = 1'b1;
                    w_index   = r_sym;
                    w_sidx    = r_cnt;
                    w_last    = w_cnt_last;
                    w_nxt_cnt = r_cnt + SW'(1);
                    if (w_cnt_last && r_sym[0]) begin
                        w_nxt_state = ST_SIG;
                        w_nxt_sym   = '0;
                    end else if (w_cnt_last) begin
                        w_nxt_sym   = LEN_WIDTH'(1);
                    end else begin
                        w_nxt_sym   = r_sym;
                    end
                end else begin
                    w_nxt_cnt = r_cnt;
                end
            end
            ST_SIG: begin
                if (w_acc_long) begin
                    w_err = 1'b1;
                end else if (w_acc_strm) begin
                    w_fft_valid = 1'b1;
                    w_fft_start = w_cnt_first;
                    w_type      = TYPE_SIG;
                    w_sidx      = r_cnt;
                    w_last      = w_cnt_last;
                    w_nxt_cnt   = r_cnt + SW'(1);
                    if (w_cnt_first && !fft_ready) begin
                        w_err = 1'b1;
                    end else if (w_cnt_last && w_lim_vld && (w_lim == '0)) begin
                        w_done = 1'b1;
                    end else if (w_cnt_last) begin
                        w_nxt_state = ST_DATA;
                        w_nxt_sym   = '0;
                    end else begin
                        w_nxt_state = ST_SIG;
                    end
                end else begin
                    w_nxt_cnt = r_cnt;
                end
            end
            ST_DATA: begin
                if (w_acc_long) begin
                    w_err = 1'b1;
                end else if (w_acc_strm) begin
                    w_fft_valid = 1'b1;
                    w_fft_start = w_cnt_first;
                    w_type      = TYPE_DATA;
                    w_index     = r_sym;
                    w_sidx      = r_cnt;
                    w_last      = w_cnt_last;
                    w_nxt_cnt   = r_cnt + SW'(1);
                    if (w_cnt_first && !fft_ready) begin
                        w_err = 1'b1;
                    end else if (w_cnt_last && w_lim_vld) begin
                        w_nxt_sym = w_sym_inc;
                        w_done    = (w_sym_inc == w_lim);
                    end else if (w_cnt_last) begin
                        w_nxt_sym = w_sym_inc;
                        w_err     = w_err | (w_sym_inc >= WAIT_SYMS);
                    end else begin
                        w_nxt_sym = r_sym;
                    end
                end else begin
                    w_nxt_cnt = r_cnt;
                end
                // A limit at or below the symbols already completed ends the frame at once.
                if (w_load_ok && (n_data_sym <= r_sym)) begin
                    w_done = 1'b1;
                end else begin
                    w_done = w_done;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; an abort suppresses the sample of that cycle.
    always_ff @(posedge CLK) begin
        if (!s_RST) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_sym            <= '0;
            r_limit          <= '0;
            r_lim_vld        <= 1'b0;
            r_idle           <= '0;
            r_fft_start      <= 1'b0;
            r_fft_in_valid   <= 1'b0;
            r_chest_wr_en    <= 1'b0;
            r_sym_type       <= TYPE_LTS;
            r_sym_index      <= '0;
            r_sample_index   <= '0;
            r_sym_last       <= 1'b0;
            r_frame_done     <= 1'b0;
            r_frame_error    <= 1'b0;
            r_sync_reset_req <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            if (w_err || w_done) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_sym     <= '0;
                r_limit   <= '0;
                r_lim_vld <= 1'b0;
                r_idle    <= '0;
            end else begin
                r_state   <= w_nxt_state;
                r_cnt     <= w_nxt_cnt;
                r_sym     <= w_nxt_sym;
                r_limit   <= w_lim;
                r_lim_vld <= w_lim_vld;
                r_idle    <= w_nxt_idle;
            end
            r_fft_start      <= w_fft_start & ~w_err;
            r_fft_in_valid   <= w_fft_valid & ~w_err;
            r_chest_wr_en    <= w_chest & ~w_err;
            r_sym_type       <= w_err ? TYPE_LTS : w_type;
            r_sym_index      <= w_err ? '0 : w_index;
            r_sample_index   <= w_err ? '0 : w_sidx;
            r_sym_last       <= w_last & ~w_err;
            r_frame_done     <= w_done & ~w_err;
            r_frame_error    <= w_err;
            r_sync_reset_req <= w_err | w_done;
            r_busy           <= ~(w_err | w_done) & (w_nxt_state != ST_IDLE);
        end
    end

    assign fft_start      = r_fft_start;
    assign fft_in_valid   = r_fft_in_valid;
    assign chest_wr_en    = r_chest_wr_en;
    assign sym_type       = r_sym_type;
    assign sym_index      = r_sym_index;
    assign sample_index   = r_sample_index;
    assign sym_last       = r_sym_last;
    assign frame_done     = r_frame_done;
    assign frame_error    = r_frame_error;
    assign sync_reset_req = r_sync_reset_req;
    assign busy           = r_busy;

endmodule

// File: doc/ofdm_symbol_scheduler.md
# ofdm_symbol_scheduler

Sequences the post-synchronisation sample stream into OFDM symbols. It takes the strobed stream from the long-preamble synchroniser, counts samples into 64-sample symbols, and tags each symbol as long-training (LTS), SIGNAL or DATA. It routes LTS samples to the channel estimator and issues per-symbol FFT starts, ends the frame after the decoded number of data symbols, and requests a synchroniser restart on completion or error.

## Interface
- SYM_LEN, 64: samples per symbol (power of two).
- LEN_WIDTH, 12: width of the data-symbol count and symbol index.
- SIG_WAIT_SYMS, 2: DATA symbols allowed to complete before `signal_valid` is required.
- TIMEOUT_CYCLES, 1023: idle clocks mid-frame before abort.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- s_RST  in  1  synchronous reset, active-low.
- in_strobe  in  1  sample valid from the synchroniser.
- in_providing_long  in  1  current strobed sample belongs to the long training field.
- in_providing_stream  in  1  current strobed sample belongs to a post-training symbol body.
- signal_valid  in  1  one-cycle pulse; SIGNAL decode finished.
- signal_ok  in  1  SIGNAL parity/rate check passed; sampled with `signal_valid`.
- n_data_sym  in  LEN_WIDTH  data-symbol count; sampled with `signal_valid`.
- fft_ready  in  1  FFT can accept a new symbol.
- fft_start  out  1  pulse on the first sample of each SIGNAL or DATA symbol.
- fft_in_valid  out  1  sample forwarded to the FFT.
- chest_wr_en  out  1  sample forwarded to the channel estimator (LTS only).
- sym_type  out  2  0 = LTS, 1 = SIGNAL, 2 = DATA.
- sym_index  out  LEN_WIDTH  LTS: 0 or 1; DATA: index starting at 0; SIGNAL: 0.
- sample_index  out  log2(SYM_LEN)  position of the sample within its symbol.
- sym_last  out  1  last sample of a symbol.
- frame_done  out  1  one-cycle pulse on normal frame end.
- frame_error  out  1  one-cycle pulse on abort.
- sync_reset_req  out  1  one-cycle pulse with `frame_done` or `frame_error`.
- busy  out  1  state is not IDLE.

## Operation
- A sample is accepted when `in_strobe` is high and exactly one of `in_providing_long` / `in_providing_stream` is high.
- States and transitions:
  - IDLE: the first accepted long sample moves to LTS and counts as LTS sample 0.
  - LTS: accepts 2*SYM_LEN long samples (symbols 0 and 1), then moves to SIGNAL.
  - SIGNAL: accepts SYM_LEN stream samples, then moves to DATA.
  - DATA: counts symbols, stays in DATA until the end condition below, then returns to IDLE.
- `n_data_sym` handling:
  - A `signal_valid` pulse in SIGNAL or DATA loads `n_data_sym` into a limit register. Pulses in IDLE or LTS are ignored; later pulses within the same frame are ignored.
  - `signal_ok` = 0 with `signal_valid` aborts the frame.
- End condition:
  - If the limit is loaded and the completed data-symbol count equals the limit at `sym_last`: pulse `frame_done` and go to IDLE.
  - Limit = 0: `frame_done` on the cycle after `signal_valid` if SIGNAL has completed, else at SIGNAL `sym_last`. Any DATA symbol in progress is dropped.
  - Limit already below the completed count when loaded: `frame_done` on the next cycle.
- Abort conditions. Each one pulses `frame_error` and `sync_reset_req`, clears all counters, and returns to IDLE:
  - both qualifiers high with `in_strobe`;
  - a stream sample in LTS;
  - a long sample in SIGNAL or DATA;
  - `fft_ready` low on a SIGNAL or DATA first sample (overrun);
  - SIG_WAIT_SYMS DATA symbols completed with no limit loaded;
  - no accepted sample for TIMEOUT_CYCLES while `busy`;
  - `signal_ok` low with `signal_valid`.
- Simultaneous events:
  - Error conditions take priority over `frame_done`.
  - A `signal_valid` arriving on the same cycle as a DATA `sym_last` is used for that symbol's end check.
- The data-symbol counter saturates at 2^LEN_WIDTH−1.

## Timing
- All outputs are registered. A sample accepted at cycle t produces `fft_in_valid` / `chest_wr_en`, tags, `fft_start` and `sym_last` at t+1.
- `frame_done` / `frame_error` / `sync_reset_req` assert at t+1 after the triggering cycle. `busy` deasserts in the same cycle.
- Reset (`s_RST` = 0 on an edge): state IDLE and every output 0 from the next cycle. Reset mid-frame discards the frame without pulsing `frame_error`.
- No stall toward the synchroniser: the stream is real-time and `fft_ready` is checked only at symbol start.
- Back-to-back frames are allowed: a long sample on the cycle after `frame_done` starts a new frame.

## Test plan
- Nominal frame: 128 long + 64 SIGNAL + 3×64 stream strobes, `signal_valid`/`signal_ok`=1/`n_data_sym`=3 during DATA symbol 0. Required: 128 `chest_wr_en`, 4 `fft_start`, `sym_index` 0..2 on DATA, `frame_done` one cycle after the 192nd stream sample.
- Gapped strobes (one every 3 clocks) with the same frame: identical tags and counts; `frame_done` one cycle after the final sample.
- `signal_ok`=0 during DATA: `frame_error` + `sync_reset_req` pulse, `busy`=0 next cycle, later stream samples ignored until a long sample arrives.
- `fft_ready`=0 on the DATA symbol 1 first sample: `frame_error`, no `fft_start` for that symbol.
- `n_data_sym`=0 arriving during SIGNAL: `frame_done` one cycle after SIGNAL `sym_last`, no DATA `fft_start`. Separately, strobes stop for 1023 clocks mid-LTS: `frame_error`.
- `s_RST` low mid-DATA: all outputs 0 next cycle, no `frame_error`; a new frame then completes normally.
